// File: rtl/ram4k_arbiter_pkg.sv
// Shared definitions for the two-port fast_ram4k arbiter: FSM state encodings
// and RAM geometry.
package ram4k_arbiter_pkg;

  localparam int RAM_ADDR_W = 12;
  localparam int RAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram4k_arbiter_ram.sv
// fast_ram4k: 4K x 16 RAM with asynchronous read and a write that commits on the
// clock edge while load is high. Contents are never reset.
module fast_ram4k
  import ram4k_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic [RAM_ADDR_W-1:0] address,
  input  logic [RAM_DATA_W-1:0] data_in,
  input  logic                  load,
  output logic [RAM_DATA_W-1:0] data_out
);

  logic [RAM_DATA_W-1:0] mem [0:(1<<RAM_ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (load) mem[address] <= data_in;
  end

  assign data_out = mem[address];

endmodule

// File: rtl/ram4k_arbiter.sv
// Two-port arbiter sharing one fast_ram4k between port 0 and port 1, with a
// burst cap on contested ownership. Define ARB_ROUND_ROBIN_EN for round-robin
// tie breaking from IDLE; otherwise port 0 wins ties.
module ram4k_arbiter
  import ram4k_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [RAM_ADDR_W-1:0] addr0,
  input  logic [RAM_DATA_W-1:0] wdata0,
  output logic                  gnt0,
  output logic [RAM_DATA_W-1:0] rdata0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [RAM_ADDR_W-1:0] addr1,
  input  logic [RAM_DATA_W-1:0] wdata1,
  output logic                  gnt1,
  output logic [RAM_DATA_W-1:0] rdata1,
  output logic                  rvalid1
);

  localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST - 1);

  arb_state_t            state, state_next, tie_state;
  logic [CNT_W-1:0]      burst_cnt, burst_cnt_next;
  logic                  access0, access1, ram_load;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic [RAM_DATA_W-1:0] ram_din, ram_dout;

  assign gnt0    = (state == OWN0);
  assign gnt1    = (state == OWN1);
  assign access0 = gnt0 && req0;
  assign access1 = gnt1 && req1;

  assign ram_addr = gnt1 ? addr1 : addr0;
  assign ram_din  = gnt1 ? wdata1 : wdata0;
  // A write presented during the reset cycle must never reach the array.
  assign ram_load = !reset && ((access0 && we0) || (access1 && we1));

  fast_ram4k u_ram (
    .clk      (clk),
    .address  (ram_addr),
    .data_in  (ram_din),
    .load     (ram_load),
    .data_out (ram_dout)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= 1'b1;
    end else if (state_next != state) begin
      if (state_next == OWN0) last_owner <= 1'b0;
      else if (state_next == OWN1) last_owner <= 1'b1;
    end
  end

  assign tie_state = last_owner ? OWN0 : OWN1;
`else
  assign tie_state = OWN0;
`endif

  always_comb begin
    state_next     = state;
    burst_cnt_next = burst_cnt;
    case (state)
      IDLE: begin
        if (req0 && req1) state_next = tie_state;
        else if (req0)    state_next = OWN0;
        else if (req1)    state_next = OWN1;
      end
      OWN0: begin
        if (!req0)                            state_next = req1 ? OWN1 : IDLE;
        else if (req1 && burst_cnt == BURST_CAP) state_next = OWN1;
        else if (burst_cnt != BURST_CAP)      burst_cnt_next = burst_cnt + 1'b1;
      end
      OWN1: begin
        if (!req1)                            state_next = req0 ? OWN0 : IDLE;
        else if (req0 && burst_cnt == BURST_CAP) state_next = OWN0;
        else if (burst_cnt != BURST_CAP)      burst_cnt_next = burst_cnt + 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (state_next != state) burst_cnt_next = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_cnt_next;
    end
  end

  // Read data is captured at the end of the access cycle and flagged for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= access0 && !we0;
      rvalid1 <= access1 && !we1;
      if (access0 && !we0) rdata0 <= ram_dout;
      if (access1 && !we1) rdata1 <= ram_dout;
    end
  end

endmodule

// File: tb/tb_ram4k_arbiter.sv
// Directed self-checking bench for ram4k_arbiter; tie-break expectations follow
// ARB_ROUND_ROBIN_EN when it is defined.
module tb_ram4k_arbiter;

  logic        clk, reset;
  logic        req0, we0, req1, we1;
  logic [11:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  int          checks;
  int          fails;

  ram4k_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({gnt0, gnt1} !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b expected 00", {gnt0, gnt1}); end
    checks++; if ({rvalid0, rvalid1} !== 2'b00) begin fails++; $display("FAIL reset_rvalid: got %b expected 00", {rvalid0, rvalid1}); end
    checks++; if ({rdata0, rdata1} !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", {rdata0, rdata1}); end
  endtask

  task automatic test_port0_rw();
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h001; wdata0 = 16'h0001;
    tick();
    checks++; if ({gnt0, gnt1} !== 2'b10) begin fails++; $display("FAIL p0_first_gnt: got %b expected 10", {gnt0, gnt1}); end
    tick();
    checks++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL p0_write_rvalid: got %b expected 0", rvalid0); end
    we0 = 1'b0;
    tick();
    checks++; if (rvalid0 !== 1'b1) begin fails++; $display("FAIL p0_read_rvalid: got %b expected 1", rvalid0); end
    checks++; if (rdata0 !== 16'h0001) begin fails++; $display("FAIL p0_read_data: got %h expected 0001", rdata0); end
    req0 = 1'b0;
    tick();
    checks++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL p0_rvalid_pulse: got %b expected 0", rvalid0); end
    checks++; if (rdata0 !== 16'h0001) begin fails++; $display("FAIL p0_rdata_hold: got %h expected 0001", rdata0); end
    checks++; if (gnt0 !== 1'b0) begin fails++; $display("FAIL p0_release: got %b expected 0", gnt0); end
  endtask

  task automatic test_shared_ram();
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'hE01; wdata1 = 16'h00FF;
    tick();
    checks++; if ({gnt0, gnt1} !== 2'b01) begin fails++; $display("FAIL p1_gnt: got %b expected 01", {gnt0, gnt1}); end
    tick();
    checks++; if (rvalid1 !== 1'b0) begin fails++; $display("FAIL p1_write_rvalid: got %b expected 0", rvalid1); end
    req1 = 1'b0;
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'hE01;
    tick();
    tick();
    checks++; if (rvalid0 !== 1'b1) begin fails++; $display("FAIL shared_rvalid0: got %b expected 1", rvalid0); end
    checks++; if (rdata0 !== 16'h00FF) begin fails++; $display("FAIL shared_rdata0: got %h expected 00ff", rdata0); end
    req0 = 1'b0;
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h001;
    tick();
    tick();
    checks++; if (rvalid1 !== 1'b1) begin fails++; $display("FAIL shared_rvalid1: got %b expected 1", rvalid1); end
    checks++; if (rdata1 !== 16'h0001) begin fails++; $display("FAIL shared_rdata1: got %h expected 0001", rdata1); end
    req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_burst();
    logic exp0, prev0, prev1;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h020;
    prev0 = 1'b0; prev1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp0 = (((i / 4) % 2) == 0);
      checks++; if ({gnt0, gnt1} !== {exp0, ~exp0}) begin fails++; $display("FAIL burst_gnt[%0d]: got %b expected %b", i, {gnt0, gnt1}, {exp0, ~exp0}); end
      checks++; if ({rvalid0, rvalid1} !== {prev0, prev1}) begin fails++; $display("FAIL burst_rvalid[%0d]: got %b expected %b", i, {rvalid0, rvalid1}, {prev0, prev1}); end
      prev0 = exp0; prev1 = ~exp0;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_tie();
    logic [1:0] exp_second;
`ifdef ARB_ROUND_ROBIN_EN
    exp_second = 2'b01;
`else
    exp_second = 2'b10;
`endif
    do_reset();
    we0 = 1'b0; we1 = 1'b0; req0 = 1'b1; req1 = 1'b1;
    tick();
    checks++; if ({gnt0, gnt1} !== 2'b10) begin fails++; $display("FAIL tie_first: got %b expected 10", {gnt0, gnt1}); end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    checks++; if ({gnt0, gnt1} !== 2'b00) begin fails++; $display("FAIL tie_idle: got %b expected 00", {gnt0, gnt1}); end
    req0 = 1'b1; req1 = 1'b1;
    tick();
    checks++; if ({gnt0, gnt1} !== exp_second) begin fails++; $display("FAIL tie_second: got %b expected %b", {gnt0, gnt1}, exp_second); end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h200; wdata0 = 16'h0007;
    tick();
    tick();
    we0 = 1'b0;
    tick();
    checks++; if (rdata0 !== 16'h0007) begin fails++; $display("FAIL mid_setup: got %h expected 0007", rdata0); end
    we0 = 1'b1; wdata0 = 16'h0003; reset = 1'b1;
    tick();
    checks++; if ({gnt0, rvalid0} !== 2'b00) begin fails++; $display("FAIL mid_after_reset: got %b expected 00", {gnt0, rvalid0}); end
    checks++; if (rdata0 !== 16'h0000) begin fails++; $display("FAIL mid_rdata_clear: got %h expected 0000", rdata0); end
    reset = 1'b0; we0 = 1'b0;
    tick();
    checks++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL mid_regrant: got %b expected 1", gnt0); end
    tick();
    checks++; if (rdata0 !== 16'h0007) begin fails++; $display("FAIL mid_write_dropped: got %h expected 0007", rdata0); end
    reset = 1'b1;
    tick();
    checks++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL mid_pending_rvalid: got %b expected 0", rvalid0); end
    reset = 1'b0; req0 = 1'b0;
    tick();
  endtask

  task automatic test_req_drop();
    do_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h300; wdata1 = 16'h1234;
    tick();
    tick();
    req1 = 1'b0;
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h000;
    tick();
    checks++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL drop_gnt0: got %b expected 1", gnt0); end
    req0 = 1'b0; we0 = 1'b1; addr0 = 12'h300; wdata0 = 16'hBEEF;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h300;
    tick();
    checks++; if ({gnt0, gnt1} !== 2'b01) begin fails++; $display("FAIL drop_handoff: got %b expected 01", {gnt0, gnt1}); end
    checks++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL drop_no_access: got %b expected 0", rvalid0); end
    tick();
    checks++; if (rdata1 !== 16'h1234) begin fails++; $display("FAIL drop_no_write: got %h expected 1234", rdata1); end
    req1 = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0; fails = 0;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    test_reset();
    test_port0_rw();
    test_shared_ram();
    test_burst();
    test_tie();
    test_reset_mid_burst();
    test_req_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
